// File: rtl/sd_spi_master_if.sv
// sd_spi_master_if
//   Byte-request bus between the RK8E command/sector engine and the SD SPI master.
//   master modport: the RK8E engine (issues requests, receives results)
//   slave  modport: sd_spi_master (accepts requests, reports busy/done/rx_byte)
//   start      1-cycle request to shift tx_byte
//   init_req   1-cycle request for the dummy-clock power-up sequence
//   tx_byte    byte to send, bit 0 is the MSB
//   cs_assert  1 = card selected during the transfer
//   fast       1 = fast SCLK rate, 0 = slow (init) rate
//   busy       transfer or init sequence in progress
//   done       1-cycle pulse at the end of a byte or init sequence
//   rx_byte    byte sampled from the card, bit 0 is the MSB
interface sd_spi_master_if;
  logic       start;
  logic       init_req;
  logic [0:7] tx_byte;
  logic       cs_assert;
  logic       fast;
  logic       busy;
  logic       done;
  logic [0:7] rx_byte;

  modport master (
    output start, init_req, tx_byte, cs_assert, fast,
    input  busy, done, rx_byte
  );

  modport slave (
    input  start, init_req, tx_byte, cs_assert, fast,
    output busy, done, rx_byte
  );
endinterface

// File: rtl/sd_spi_master.sv
// sd_spi_master
//   Byte-level SPI master (mode 0, MSB first) for an SD card, plus generation
//   of the power-up sequence of INIT_CLKS dummy clocks with the card deselected.
//   clk     system clock (single domain)
//   resetn  asynchronous active-low reset
//   bus     request/result bus (slave side of sd_spi_master_if)
//   sdCS    card chip select, active low
//   sdSCLK  SPI clock, idles low
//   sdMOSI  data to card, idles high
//   sdMISO  data from card, sampled on the SCLK rising edge
module sd_spi_master #(
  parameter int SLOW_DIV  = 125,
  parameter int FAST_DIV  = 2,
  parameter int INIT_CLKS = 80
) (
  input  logic           clk,
  input  logic           resetn,
  sd_spi_master_if.slave bus,
  output logic           sdCS,
  output logic           sdSCLK,
  output logic           sdMOSI,
  input  logic           sdMISO
);

  localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int BW = $clog2(INIT_CLKS + 1);
  localparam logic [CW-1:0] SLOW_LD = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_LD = CW'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;     // half-period down-counter
  logic [CW-1:0] div_r, div_s;     // half-period reload value, latched at accept
  logic [CW-1:0] load_s;
  logic [BW-1:0] bit_r, bit_s;     // remaining SCLK periods
  logic [0:7]    tx_r, tx_s;       // outgoing bits, tx_r[0] is on sdMOSI
  logic [0:7]    rxsh_r, rxsh_s;   // incoming bits, newest at index 7
  logic [0:7]    rx_r, rx_s;
  logic          sclk_r, sclk_s;
  logic          mosi_r, mosi_s;
  logic          cs_r, cs_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    div_s   = div_r;
    bit_s   = bit_r;
    tx_s    = tx_r;
    rxsh_s  = rxsh_r;
    rx_s    = rx_r;
    sclk_s  = sclk_r;
    mosi_s  = mosi_r;
    cs_s    = cs_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    load_s  = bus.fast ? FAST_LD : SLOW_LD;
    case (state_r)
      // FIN accepts a new request exactly like IDLE so bytes can run back to back.
      IDLE, FIN: begin
        sclk_s = 1'b0;
        mosi_s = 1'b1;
        busy_s = 1'b0;
        // Chip select stays frozen through FIN and only tracks cs_assert in IDLE.
        if (state_r == FIN) begin
          cs_s = cs_r;
        end else begin
          cs_s = ~bus.cs_assert;
        end
        // init_req has priority; a simultaneous start is dropped.
        if (bus.init_req) begin
          div_s   = load_s;
          cnt_s   = load_s;
          bit_s   = BW'(INIT_CLKS);
          tx_s    = 8'hFF;
          cs_s    = 1'b1;
          busy_s  = 1'b1;
          state_s = LOW;
        end else if (bus.start) begin
          div_s   = load_s;
          cnt_s   = load_s;
          bit_s   = BW'(8);
          tx_s    = bus.tx_byte;
          mosi_s  = bus.tx_byte[0];
          cs_s    = ~bus.cs_assert;
          busy_s  = 1'b1;
          state_s = LOW;
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (cnt_r == {CW{1'b0}}) begin
          sclk_s  = 1'b1;
          rxsh_s  = {rxsh_r[1:7], sdMISO};
          cnt_s   = div_r;
          state_s = HIGH;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_r == {CW{1'b0}}) begin
          sclk_s = 1'b0;
          cnt_s  = div_r;
          bit_s  = bit_r - BW'(1);
          if (bit_r == BW'(1)) begin
            mosi_s  = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            rx_s    = rxsh_r;
            state_s = FIN;
          end else begin
            tx_s    = {tx_r[1:7], 1'b1};
            mosi_s  = tx_r[1];
            state_s = LOW;
          end
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      div_r   <= {CW{1'b0}};
      bit_r   <= {BW{1'b0}};
      tx_r    <= 8'hFF;
      rxsh_r  <= 8'h00;
      rx_r    <= 8'h00;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b1;
      cs_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      tx_r    <= tx_s;
      rxsh_r  <= rxsh_s;
      rx_r    <= rx_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      cs_r    <= cs_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign sdCS        = cs_r;
  assign sdSCLK      = sclk_r;
  assign sdMOSI      = mosi_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_byte = rx_r;

endmodule
